// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, widths and GF(2^8) helper
package aes_pkg;
  localparam int NUM_WORDS = 4;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/inv_mixw.sv
// rtl/inv_mixw.sv - inverse MixColumns of one 32-bit column (a0 in bits [31:24])
module inv_mixw
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);
  logic [7:0] w_a   [4];
  logic [7:0] w_x2  [4];
  logic [7:0] w_x4  [4];
  logic [7:0] w_x8  [4];
  logic [7:0] w_m9  [4];
  logic [7:0] w_m11 [4];
  logic [7:0] w_m13 [4];
  logic [7:0] w_m14 [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign w_a[i]   = i_word[31-8*i -: 8];
    assign w_x2[i]  = xtime(w_a[i]);
    assign w_x4[i]  = xtime(w_x2[i]);
    assign w_x8[i]  = xtime(w_x4[i]);
    assign w_m9[i]  = w_x8[i] ^ w_a[i];
    assign w_m11[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
    assign w_m13[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
    assign w_m14[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
  end

  // Row j of the circulant matrix {0e,0b,0d,09} rotated right by j.
  for (genvar j = 0; j < 4; j++) begin : g_out
    assign o_word[31-8*j -: 8] = w_m14[j] ^ w_m11[(j+1)%4] ^ w_m13[(j+2)%4] ^ w_m9[(j+3)%4];
  end
endmodule

// File: rtl/aes_inv_mix_seq.sv
// rtl/aes_inv_mix_seq.sv - column-serial AES inverse MixColumns sequencer
// COLS inv_mixw units walk the state from word 3 down to word 0; bypass copies in one cycle.
module aes_inv_mix_seq
  import aes_pkg::*;
#(
  parameter int COLS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);
  if (COLS != 1 && COLS != 2 && COLS != 4) begin : g_bad_cols
    $error("aes_inv_mix_seq: COLS must be 1, 2 or 4");
  end

  state_t              r_state;
  state_t              w_next;
  logic [BLOCK_W-1:0]  r_src;
  logic [BLOCK_W-1:0]  r_res;
  logic                r_byp;
  logic [1:0]          r_idx;
  logic                w_accept;
  logic                w_last;
  logic [1:0]          w_widx [COLS];
  logic [WORD_W-1:0]   w_mix  [COLS];

  for (genvar k = 0; k < COLS; k++) begin : g_col
    assign w_widx[k] = 2'(NUM_WORDS - 1 - k) - r_idx;
    inv_mixw u_mixw (
      .i_word (r_src[w_widx[k]*WORD_W +: WORD_W]),
      .o_word (w_mix[k])
    );
  end

  assign w_accept = in_valid & in_ready;
  // The step that reaches word 0 is the last; counter wraps so COLS=4 always ends at idx 0.
  assign w_last   = r_byp | (r_idx == 2'(NUM_WORDS - COLS));
  assign out_data = r_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = in_valid ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    out_valid = (r_state == DONE);
    busy      = (r_state == BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src <= '0;
      r_res <= '0;
      r_byp <= 1'b0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_src <= in_data;
      r_byp <= in_bypass;
      r_idx <= '0;
    end else if (r_state == BUSY) begin
      if (r_byp) begin
        r_res <= r_src;
      end else begin
        for (int k = 0; k < COLS; k++) begin
          r_res[w_widx[k]*WORD_W +: WORD_W] <= w_mix[k];
        end
        r_idx <= r_idx + 2'(COLS);
      end
    end
  end
endmodule

// File: doc/aes_inv_mix_seq.md
Name: aes_inv_mix_seq

Overview:
Column-serial sequencer for the AES inverse MixColumns step in the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and runs it through COLS instances of the existing inv_mixw word unit over 4/COLS cycles. It returns the result over a second valid/ready handshake. A per-block bypass flag passes data through unchanged, for the final decryption round where no MixColumns is applied. The block trades throughput for area against the fully parallel four-word inverse MixColumns unit.

Parameters:
COLS, 1, number of inv_mixw instances, which is also the number of columns processed per cycle; legal values are 1, 2 and 4 (elaboration error otherwise).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input block valid
in_ready  out  1  block can accept input
in_data  in  128  AES state; word 3 = bits[127:96] is column 0, word 0 = bits[31:0] is column 3; byte a0 of each word is in bits [31:24]
in_bypass  in  1  sampled with in_data; 1 = output equals input
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  128  result block
busy  out  1  high in BUSY state

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, column counter=0, data/result registers=0.
- States and transitions:
  - IDLE -> BUSY on in_valid & in_ready. The input handshake loads src_reg ← in_data and byp ← in_bypass, and clears the counter.
  - BUSY: every cycle, words are selected by counter idx (step COLS, starting at word 3 and descending).
    - Each selected word goes through inv_mixw and is written into the matching word of res_reg; counter increments by COLS.
    - After the cycle that writes word 0: BUSY -> DONE.
    - If byp=1: BUSY lasts exactly one cycle and res_reg ← src_reg.
  - DONE: out_valid=1 and out_data=res_reg, held stable until out_ready.
    - On out_valid & out_ready with no new input: DONE -> IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). A new block accepted in the same cycle as the output handshake goes DONE -> BUSY with no bubble.
- in_ready never depends on in_valid (no combinational in→in loop). out_valid is registered.
- Latency from the input-handshake edge T:
  - out_valid is first high after edge T+4/COLS (COLS=1: 4 cycles; COLS=2: 2; COLS=4: 1).
  - Bypass latency is 1 cycle for every COLS.
- Throughput with out_ready held at 1: one block per 4/COLS cycles, plus 1 cycle per block for the DONE handshake.
- in_valid while BUSY is ignored (in_ready=0). in_data and in_bypass are don't-care outside the input handshake.
- Counter wraps mod 4. It is unused outside BUSY and is cleared on load.
- out_ready held at 0: the block stalls in DONE indefinitely and out_data does not change.
- Reset asserted mid-BUSY or mid-DONE: the block in flight is discarded and all outputs go to their reset values immediately.

Decomposition:
- Shared package aes_pkg holds:
  - state enum {IDLE, BUSY, DONE}, 2 bits;
  - NUM_WORDS=4;
  - WORD_W=32;
  - BLOCK_W=128.
- Sub-module: inv_mixw, instantiated COLS times via generate. Each instance's input word is muxed from src_reg by counter.
- No other sub-modules; the FSM, counter and registers are local.

Test Plan:
- Known vector, COLS=1: in_data=8e4da1bc_01010101_d5d5d7d6_c6c6c6c6, bypass=0, out_ready=1 → out_data=db135345_01010101_d4d4d4d5_c6c6c6c6. out_valid rises exactly 4 cycles after the accept edge; busy is high for 4 cycles.
- Same vector with COLS=2 and COLS=4 → identical out_data at latency 2 and 1 respectively.
- Bypass: in_data=00112233_44556677_8899aabb_ccddeeff, in_bypass=1 → out_data equals in_data after 1 cycle, for every COLS.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_valid and out_data stable and in_ready=0. On out_ready=1 with in_valid=1 and a second block, both handshakes occur in one cycle and the second result follows 4/COLS cycles later.
- Reset mid-operation: assert rst 2 cycles into BUSY (COLS=1) → in_ready=1, out_valid=0, busy=0, out_data=0 while rst is high. After release, the known vector completes correctly.
- Random regression: 1000 random blocks with random in_valid, out_ready and bypass → every output matches a golden model (inverse of GF(2^8) MixColumns per word, or identity when bypass), in order, with no drops or duplicates.
